// File: rtl/sp_ram_ctrl_if.sv
// Request/response bus between a requester and sp_ram_ctrl.
// master: drives requests and RSP_READY; slave: drives REQ_READY and the
// registered read response (RSP_VALID/RSP_DATA/RSP_ERR).
interface sp_ram_ctrl_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STRB_WIDTH = 8
);
  localparam int unsigned NLANE = WIDTH / STRB_WIDTH;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_WRITE;
  logic [AW-1:0]    REQ_ADDR;
  logic [WIDTH-1:0] REQ_DATA;
  logic [NLANE-1:0] REQ_STRB;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [WIDTH-1:0] RSP_DATA;
  logic             RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA, REQ_STRB, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA, REQ_STRB, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Front-end for a single-port RAM with combinational read data.
// After reset it clears every entry to zero (INIT), then serves strobed
// writes and reads (RUN) with a one-deep registered response buffer.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   bus         request/response channel (slave side)
//   INIT_DONE   high from the first RUN cycle until the next reset
//   RAM_ADDR/RAM_D/RAM_W_EN  to the RAM; RAM_Q  from the RAM
module sp_ram_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STRB_WIDTH = 8,
  localparam int unsigned NLANE     = WIDTH / STRB_WIDTH,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  sp_ram_ctrl_if.slave     bus,
  output logic             INIT_DONE,
  output logic [AW-1:0]    RAM_ADDR,
  output logic [WIDTH-1:0] RAM_D,
  output logic [NLANE-1:0] RAM_W_EN,
  input  logic [WIDTH-1:0] RAM_Q
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             init_done_q;
  logic             req_ready;
  logic             addr_ok;
  logic             accept;

  // Next-state, RAM drive and response-buffer update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    req_ready   = 1'b0;
    accept      = 1'b0;
    RAM_ADDR    = cnt_q;
    RAM_D       = '0;
    RAM_W_EN    = '0;
    addr_ok     = ({1'b0, bus.REQ_ADDR} < DEPTH_V);

    unique case (state_q)
      S_INIT: begin
        // Write enables are held off while reset is asserted.
        if (RST_N) RAM_W_EN = '1;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Buffer can take a new read if empty or draining this edge.
        req_ready = !rsp_valid_q || bus.RSP_READY;
        accept    = bus.REQ_VALID && req_ready;
        RAM_ADDR  = bus.REQ_ADDR;
        RAM_D     = bus.REQ_DATA;
        if (rsp_valid_q && bus.RSP_READY) rsp_valid_d = 1'b0;
        if (accept && bus.REQ_WRITE && addr_ok) RAM_W_EN = bus.REQ_STRB;
        if (accept && !bus.REQ_WRITE) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = addr_ok ? RAM_Q : '0;
          rsp_err_d   = !addr_ok;
        end
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= (state_d == S_RUN);
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign INIT_DONE     = init_done_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Scoreboard bench for sp_ram_ctrl (WIDTH=32, STRB_WIDTH=8, DEPTH=6) with a
// behavioural RAM that returns garbage for out-of-range addresses.
module tb_sp_ram_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 6;
  localparam int unsigned SW = 8;
  localparam int unsigned NL = W / SW;
  localparam int unsigned AW = 3;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_d;
  logic [NL-1:0] ram_w_en;
  logic [W-1:0]  ram_q;

  logic [W-1:0]  mem [D];
  logic [W-1:0]  model [D];
  exp_t          exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            rand_rdy = 0;

  sp_ram_ctrl_if #(.WIDTH(W), .DEPTH(D), .STRB_WIDTH(SW)) bus ();

  sp_ram_ctrl #(.WIDTH(W), .DEPTH(D), .STRB_WIDTH(SW)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .bus       (bus),
    .INIT_DONE (init_done),
    .RAM_ADDR  (ram_addr),
    .RAM_D     (ram_d),
    .RAM_W_EN  (ram_w_en),
    .RAM_Q     (ram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: lane-strobed write, combinational read.
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++)
      if (ram_w_en[l] && ram_addr < AW'(D)) mem[ram_addr][l*SW +: SW] <= ram_d[l*SW +: SW];
  end
  assign ram_q = (ram_addr < AW'(D)) ? mem[ram_addr] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected accept (t=%0t)", name, $time);
  endtask

  // Scoreboard monitor: pop one expectation per response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.RSP_VALID && bus.RSP_READY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got data %0h expected no response", bus.RSP_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 64'(bus.RSP_DATA), 64'(e.data));
          chk("rsp_err", 64'(bus.RSP_ERR), 64'(e.err));
        end
      end
    end
  end

  // Random response back-pressure for the mixed phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.RSP_READY = 1'($urandom_range(0, 1));
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NL-1:0] s);
    bit   done = 0;
    logic rdy;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = 1'b1;
    bus.REQ_ADDR  = a;
    bus.REQ_DATA  = d;
    bus.REQ_STRB  = s;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = bus.REQ_READY;
      if (rdy) chk("wr_wen", 64'(ram_w_en), (a < AW'(D)) ? 64'(s) : 64'd0);
      @(posedge clk);
      if (rdy) done = 1;
    end
    if (!done) fail_timeout("wr_accept");
    else if (a < AW'(D))
      for (int l = 0; l < NL; l++)
        if (s[l]) model[a][l*SW +: SW] = d[l*SW +: SW];
    #1;
    bus.REQ_VALID = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] ed, input logic ee);
    bit   done = 0;
    logic rdy;
    exp_t e;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR  = a;
    bus.REQ_DATA  = '0;
    bus.REQ_STRB  = '0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = bus.REQ_READY;
      @(posedge clk);
      if (rdy) done = 1;
    end
    if (!done) fail_timeout("rd_accept");
    else begin
      e.data = ed;
      e.err  = ee;
      exp_q.push_back(e);
    end
    #1;
    bus.REQ_VALID = 1'b0;
  endtask

  // Called at posedge+1 right after reset release; checks the clear sweep.
  task automatic init_seq();
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("init_addr", 64'(ram_addr), 64'(i));
      chk("init_wen", 64'(ram_w_en), 64'hF);
      chk("init_d", 64'(ram_d), 64'd0);
      chk("init_ready", 64'(bus.REQ_READY), 64'd0);
      chk("init_done_lo", 64'(init_done), 64'd0);
    end
    @(negedge clk);
    chk("init_done_hi", 64'(init_done), 64'd1);
    chk("run_ready", 64'(bus.REQ_READY), 64'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < D; k++) model[k] = '0;
  endtask

  task automatic reset_checks();
    chk("rst_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("rst_req_ready", 64'(bus.REQ_READY), 64'd0);
    chk("rst_wen", 64'(ram_w_en), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [W-1:0]  ed;
    for (int k = 0; k < D; k++) mem[k] = 32'h5A5A_5A5A;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_DATA  = '0;
    bus.REQ_STRB  = '0;
    bus.RSP_READY = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    chk("rst_rsp_data", 64'(bus.RSP_DATA), 64'd0);
    chk("rst_rsp_err", 64'(bus.RSP_ERR), 64'd0);
    rst_n = 1'b1;
    init_seq();

    // Partial-strobe overwrite, read-after-write, one-cycle latency.
    wr(3'd3, 32'hAABB_CCDD, 4'b1111);
    wr(3'd3, 32'h1122_3344, 4'b0101);
    rd(3'd3, 32'hAA22_CC44, 1'b0);
    @(negedge clk);
    chk("rd_latency", 64'(bus.RSP_VALID), 64'd1);
    @(posedge clk);
    #1;

    // Out-of-range write and read, cleared entry, zero strobe.
    wr(3'd7, 32'h0000_00FF, 4'b1111);
    rd(3'd7, 32'h0, 1'b1);
    rd(3'd5, 32'h0, 1'b0);
    wr(3'd2, 32'h1234_5678, 4'b0000);
    rd(3'd2, 32'h0, 1'b0);

    // Back-pressure: second read waits, then is accepted on the drain edge.
    wr(3'd1, 32'h0101_0101, 4'b1111);
    wr(3'd2, 32'h0202_0202, 4'b1111);
    bus.RSP_READY = 1'b0;
    rd(3'd1, 32'h0101_0101, 1'b0);
    fork
      rd(3'd2, 32'h0202_0202, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_req_ready", 64'(bus.REQ_READY), 64'd0);
          chk("bp_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
          chk("bp_rsp_hold", 64'(bus.RSP_DATA), 64'h0101_0101);
        end
        @(posedge clk);
        #1;
        bus.RSP_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.RSP_READY = 1'b0;
      end
    join
    @(negedge clk);
    chk("bp_pass_valid", 64'(bus.RSP_VALID), 64'd1);
    chk("bp_pass_data", 64'(bus.RSP_DATA), 64'h0202_0202);
    @(posedge clk);
    #1;
    bus.RSP_READY = 1'b1;
    @(posedge clk);
    #1;

    // Reset while a response is pending.
    bus.RSP_READY = 1'b0;
    rd(3'd4, 32'h0, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 64'(bus.RSP_VALID), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.RSP_READY = 1'b1;
    rst_n = 1'b1;
    init_seq();

    // Reset at INIT count 4; sweep restarts from 0.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_init_addr", 64'(ram_addr), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_seq();
    rd(3'd3, 32'h0, 1'b0);

    // Random mix against the memory model.
    rand_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      a = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) wr(a, $urandom, NL'($urandom));
      else begin
        ed = (a < AW'(D)) ? model[a] : '0;
        rd(a, ed, a >= AW'(D));
      end
    end
    rand_rdy = 0;
    @(posedge clk);
    #1;
    bus.RSP_READY = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
